// File: rtl/fluxo_dados_rodadas_pkg.sv
// ============================================================================
// fluxo_dados_rodadas_pkg
// Shared defaults and counter-mode type for the sequence-game datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fluxo_dados_rodadas_pkg;

  localparam int unsigned c_n_chaves = 4;
  localparam int unsigned c_addr_w   = 4;
  localparam int unsigned c_timeout  = 5000;
  localparam int unsigned c_depth    = 1 << c_addr_w;
  localparam int unsigned c_tw       = $clog2(c_timeout);

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

endpackage

`default_nettype wire

// File: rtl/fluxo_dados_rodadas_contador.sv
// ============================================================================
// contador_m
// Up-counter with sync clear, enable, wrap/saturate at MAX and an at-MAX flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module contador_m
  import fluxo_dados_rodadas_pkg::*;
#(
  parameter int unsigned     W    = 4,
  parameter logic [W-1:0]    MAX  = '1,
  parameter cnt_mode_e       MODE = CNT_WRAP
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera_i,
  input  logic         conta_i,
  output logic [W-1:0] q_o,
  output logic         fim_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (zera_i) begin
      cnt_d = '0;
    end else if (conta_i) begin
      if (cnt_q == MAX) begin
        cnt_d = (MODE == CNT_SAT) ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o   = cnt_q;
  assign fim_o = (cnt_q == MAX);

endmodule

`default_nettype wire

// File: rtl/fluxo_dados_rodadas_rom.sv
// ============================================================================
// sync_rom_param
// Synchronous-read pattern ROM; contents come from a packed image parameter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_rom_param #(
  parameter int unsigned                         ADDR_W = 4,
  parameter int unsigned                         DATA_W = 4,
  parameter logic [(2**ADDR_W)*DATA_W-1:0]       IMAGE  = '0
) (
  input  logic              clock,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] data_q;

  // Word i lives at IMAGE[i*DATA_W +: DATA_W]
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom_words
    assign mem[g] = IMAGE[g*DATA_W +: DATA_W];
  end

  always_ff @(posedge clock) begin
    data_q <= mem[addr_i];
  end

  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/fluxo_dados_rodadas.sv
// ============================================================================
// fluxo_dados_rodadas
// Sequence-game datapath: address/limit/timeout counters, play register,
// pattern ROM, key-edge detector and multi-key check.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fluxo_dados_rodadas
  import fluxo_dados_rodadas_pkg::*;
#(
  parameter int unsigned N_CHAVES = c_n_chaves,
  parameter int unsigned ADDR_W   = c_addr_w,
  parameter int unsigned TIMEOUT  = c_timeout,
  parameter logic [(2**ADDR_W)*N_CHAVES-1:0] ROM_IMAGE =
    {(2**ADDR_W){{{(N_CHAVES-1){1'b0}}, 1'b1}}}
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                zeraE,
  input  logic                contaE,
  input  logic                zeraL,
  input  logic                contaL,
  input  logic                zeraR,
  input  logic                registraR,
  input  logic                zeraT,
  input  logic                contaT,
  input  logic [N_CHAVES-1:0] chaves,
  output logic                chavesIgualMemoria,
  output logic                enderecoIgualLimite,
  output logic                fimE,
  output logic                fimL,
  output logic                timeout,
  output logic                jogada_feita,
  output logic                jogada_invalida,
  output logic                db_tem_jogada,
  output logic [ADDR_W-1:0]   db_contagem,
  output logic [ADDR_W-1:0]   db_limite,
  output logic [N_CHAVES-1:0] db_jogada,
  output logic [N_CHAVES-1:0] db_memoria
);

  localparam int unsigned  TW   = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   limite;
  logic [TW-1:0]       tcnt_unused;
  logic [N_CHAVES-1:0] mem_data;
  logic [N_CHAVES-1:0] play_q;
  logic                hist_q;
  logic                feita_q;
  logic                tem_jogada;

  contador_m #(.W(ADDR_W), .MAX('1), .MODE(CNT_WRAP)) u_cnt_e (
    .clock   (clock),
    .reset   (reset),
    .zera_i  (zeraE),
    .conta_i (contaE),
    .q_o     (addr),
    .fim_o   (fimE)
  );

  contador_m #(.W(ADDR_W), .MAX('1), .MODE(CNT_WRAP)) u_cnt_l (
    .clock   (clock),
    .reset   (reset),
    .zera_i  (zeraL),
    .conta_i (contaL),
    .q_o     (limite),
    .fim_o   (fimL)
  );

  contador_m #(.W(TW), .MAX(TMAX), .MODE(CNT_SAT)) u_cnt_t (
    .clock   (clock),
    .reset   (reset),
    .zera_i  (zeraT),
    .conta_i (contaT),
    .q_o     (tcnt_unused),
    .fim_o   (timeout)
  );

  sync_rom_param #(.ADDR_W(ADDR_W), .DATA_W(N_CHAVES), .IMAGE(ROM_IMAGE)) u_rom (
    .clock  (clock),
    .addr_i (addr),
    .data_o (mem_data)
  );

  always_ff @(posedge clock) begin
    if (reset || zeraR) begin
      play_q <= '0;
    end else if (registraR) begin
      play_q <= chaves;
    end
  end

  assign tem_jogada = |chaves;

  // Loading a play re-arms the detector so a key still held pulses again
  always_ff @(posedge clock) begin
    if (reset || registraR) begin
      hist_q  <= 1'b0;
      feita_q <= 1'b0;
    end else begin
      hist_q  <= tem_jogada;
      feita_q <= tem_jogada & ~hist_q;
    end
  end

  assign chavesIgualMemoria  = (play_q == mem_data);
  assign enderecoIgualLimite = (addr == limite);
  assign jogada_feita        = feita_q;
  assign jogada_invalida     = ($countones(chaves) > 1);
  assign db_tem_jogada       = tem_jogada;
  assign db_contagem         = addr;
  assign db_limite           = limite;
  assign db_jogada           = play_q;
  assign db_memoria          = mem_data;

endmodule

`default_nettype wire

// File: tb/tb_fluxo_dados_rodadas.sv
// ============================================================================
// tb_fluxo_dados_rodadas
// Directed plus randomized checks against an arithmetic model of the datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fluxo_dados_rodadas;

  localparam int NK = 4;
  localparam int AW = 4;
  localparam int TO = 8;
  localparam logic [63:0] C_IMG = 64'h2411_8142_2814_8421;

  logic          clock = 1'b0;
  logic          reset, zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT;
  logic [NK-1:0] chaves;
  logic          chavesIgualMemoria, enderecoIgualLimite, fimE, fimL, timeout;
  logic          jogada_feita, jogada_invalida, db_tem_jogada;
  logic [AW-1:0] db_contagem, db_limite;
  logic [NK-1:0] db_jogada, db_memoria;

  fluxo_dados_rodadas #(.N_CHAVES(NK), .ADDR_W(AW), .TIMEOUT(TO), .ROM_IMAGE(C_IMG)) dut (
    .clock(clock), .reset(reset),
    .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR), .zeraT(zeraT), .contaT(contaT),
    .chaves(chaves),
    .chavesIgualMemoria(chavesIgualMemoria), .enderecoIgualLimite(enderecoIgualLimite),
    .fimE(fimE), .fimL(fimL), .timeout(timeout),
    .jogada_feita(jogada_feita), .jogada_invalida(jogada_invalida),
    .db_tem_jogada(db_tem_jogada), .db_contagem(db_contagem), .db_limite(db_limite),
    .db_jogada(db_jogada), .db_memoria(db_memoria)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [3:0] rom_tb [16];
  int         m_addr, m_lim, m_tcnt;
  logic [3:0] m_play, m_mem;
  bit         m_hist, m_feita, m_mem_ok, m_addr_known;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied
  task automatic model_edge();
    bit tem;
    tem      = (chaves != 0);
    m_mem_ok = m_addr_known;
    m_mem    = rom_tb[m_addr];
    if (reset) begin
      m_addr = 0; m_lim = 0; m_tcnt = 0; m_play = 0;
      m_hist = 0; m_feita = 0; m_addr_known = 1;
    end else begin
      if (zeraE) m_addr = 0; else if (contaE) m_addr = (m_addr + 1) % 16;
      if (zeraL) m_lim = 0;  else if (contaL) m_lim = (m_lim + 1) % 16;
      if (zeraT) m_tcnt = 0; else if (contaT && m_tcnt < TO - 1) m_tcnt = m_tcnt + 1;
      if (zeraR) m_play = 0; else if (registraR) m_play = chaves;
      if (registraR) begin
        m_hist = 0; m_feita = 0;
      end else begin
        m_feita = tem && !m_hist;
        m_hist  = tem;
      end
    end
  endtask

  task automatic check_all();
    int ones;
    ones = $countones(chaves);
    check("contagem", 32'(db_contagem), 32'(m_addr));
    check("limite",   32'(db_limite),   32'(m_lim));
    check("jogada",   32'(db_jogada),   32'(m_play));
    check("timeout",  32'(timeout),     32'(m_tcnt == TO - 1));
    check("feita",    32'(jogada_feita), 32'(m_feita));
    check("fimE",     32'(fimE),        32'(m_addr == 15));
    check("fimL",     32'(fimL),        32'(m_lim == 15));
    check("endIgLim", 32'(enderecoIgualLimite), 32'(m_addr == m_lim));
    check("invalida", 32'(jogada_invalida), 32'(ones > 1));
    check("tem",      32'(db_tem_jogada), 32'(ones > 0));
    if (m_mem_ok) begin
      check("memoria",  32'(db_memoria), 32'(m_mem));
      check("chIgMem",  32'(chavesIgualMemoria), 32'(m_play == m_mem));
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    check_all();
  endtask

  initial begin
    logic [63:0] img;
    int pulses, first_to;
    img = C_IMG;
    for (int i = 0; i < 16; i++) rom_tb[i] = img[i*4 +: 4];
    m_addr = 0; m_lim = 0; m_tcnt = 0; m_play = 0; m_mem = 0;
    m_hist = 0; m_feita = 0; m_mem_ok = 0; m_addr_known = 0;
    {zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT} = '0;
    chaves = '0;

    // Reset state, then ROM[0] one cycle later
    reset = 1'b1; tick(); reset = 1'b0;
    tick();
    check("rst_mem", 32'(db_memoria), 32'(rom_tb[0]));

    // Address counter full lap
    contaE = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 14) check("fimE_at15", 32'(fimE), 32'd1);
    end
    check("wrapE", 32'(db_contagem), 32'd0);
    contaE = 1'b0;

    // Limit vs address equality, clear beats count
    contaL = 1'b1; repeat (3) tick(); contaL = 1'b0;
    contaE = 1'b1; repeat (3) tick(); contaE = 1'b0;
    check("eq_3", 32'(enderecoIgualLimite), 32'd1);
    zeraE = 1'b1; contaE = 1'b1; tick(); zeraE = 1'b0; contaE = 1'b0;
    check("zera_wins", 32'(db_contagem), 32'd0);

    // Move to address 2 (ROM word 0100) and let the ROM catch up
    contaE = 1'b1; repeat (2) tick(); contaE = 1'b0; tick();

    // Held key gives one pulse; registraR loads it and re-arms
    pulses = 0;
    chaves = 4'b0100;
    repeat (5) begin tick(); if (jogada_feita) pulses++; end
    check("one_pulse", 32'(pulses), 32'd1);
    registraR = 1'b1; tick(); registraR = 1'b0;
    check("db_jogada", 32'(db_jogada), 32'h4);
    check("igual_mem", 32'(chavesIgualMemoria), 32'd1);
    tick();
    check("rearm", 32'(jogada_feita), 32'd1);

    // Multi-key detection is combinational
    chaves = 4'b0110; #1;
    check("inval_hi", 32'(jogada_invalida), 32'd1);
    check("tem_hi",   32'(db_tem_jogada),   32'd1);
    chaves = 4'b0000; #1;
    check("inval_lo", 32'(jogada_invalida), 32'd0);
    check("tem_lo",   32'(db_tem_jogada),   32'd0);
    tick();

    // Timeout: observed right after the 7th counting edge, i.e. in the 8th cycle
    first_to = -1;
    contaT = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (timeout && first_to < 0) first_to = i;
    end
    check("to_cycle", 32'(first_to), 32'd7);
    check("to_hold",  32'(timeout),  32'd1);
    contaT = 1'b0; zeraT = 1'b1; tick(); zeraT = 1'b0;
    check("to_clear", 32'(timeout), 32'd0);
    contaT = 1'b1; repeat (3) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (7) tick();
    check("to_restart", 32'(timeout), 32'd1);
    contaT = 1'b0;

    // Reset suppresses a pending edge pulse
    chaves = 4'b0000; tick();
    chaves = 4'b0001; reset = 1'b1; tick(); reset = 1'b0;
    check("rst_suppress", 32'(jogada_feita), 32'd0);
    tick();

    // Randomized control and key traffic
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(39) == 0);
      zeraE     = ($urandom_range(15) == 0);
      contaE    = 1'($urandom_range(1));
      zeraL     = ($urandom_range(15) == 0);
      contaL    = 1'($urandom_range(1));
      zeraR     = ($urandom_range(15) == 0);
      registraR = ($urandom_range(5) == 0);
      zeraT     = ($urandom_range(19) == 0);
      contaT    = ($urandom_range(3) != 0);
      chaves    = ($urandom_range(2) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(3));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
